// File: rtl/ir_nec_rx.sv
// rtl/ir_nec_rx.sv - NEC infrared frame receiver (address/command decode, repeat codes, timeouts)
//
// Parameters:
//   DIV_LOG2        tick = clk / 2^DIV_LOG2; all pulse lengths are measured in ticks
//   CNT_W           width of the saturating pulse-length counter
//   LEAD_MARK_MIN   minimum leader mark
//   LEAD_SPACE_MIN  leader space at or above this starts a data frame
//   REP_SPACE_MIN   leader space in [REP_SPACE_MIN, LEAD_SPACE_MIN) is a repeat code
//   BIT_MARK_MAX    longest acceptable bit/stop mark
//   BIT1_MIN        bit space at or above this decodes as a one
//   MAX_PULSE       any mark or space reaching this length aborts the frame
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ir_in         raw demodulated IR line, asynchronous, idle high, mark low
//   cmd_valid     one-clk strobe, valid frame decoded
//   cmd_addr      last valid address
//   cmd_code      last valid command
//   repeat_pulse  one-clk strobe, valid repeat code after a good frame
//   frame_err     one-clk strobe, malformed or aborted frame
//   busy          decoder is not idle
//
// Build option: define IR_EXT_ADDR_EN for extended NEC (16-bit address,
// no address inverse check). Without it both inverse checks apply.

module ir_nec_rx #(
    parameter int DIV_LOG2       = 11,
    parameter int CNT_W          = 10,
    parameter int LEAD_MARK_MIN  = 300,
    parameter int LEAD_SPACE_MIN = 140,
    parameter int REP_SPACE_MIN  = 70,
    parameter int BIT_MARK_MAX   = 40,
    parameter int BIT1_MIN       = 44,
    parameter int MAX_PULSE      = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_in,
    output logic        cmd_valid,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_code,
    output logic        repeat_pulse,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_REP_STOP
    } state_t;

    localparam logic [CNT_W-1:0] LEAD_MARK_C  = CNT_W'(LEAD_MARK_MIN);
    localparam logic [CNT_W-1:0] LEAD_SPACE_C = CNT_W'(LEAD_SPACE_MIN);
    localparam logic [CNT_W-1:0] REP_SPACE_C  = CNT_W'(REP_SPACE_MIN);
    localparam logic [CNT_W-1:0] BIT_MARK_C   = CNT_W'(BIT_MARK_MAX);
    localparam logic [CNT_W-1:0] BIT1_C       = CNT_W'(BIT1_MIN);
    // Abort on the tick that would carry len up to MAX_PULSE.
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(MAX_PULSE - 1);
    localparam logic [CNT_W-1:0] LEN_SAT      = '1;
    localparam logic [CNT_W-1:0] LEN_ONE      = CNT_W'(1);

    // Input conditioning and tick-rate sampling
    logic                sync1;
    logic                sync2;
    logic [DIV_LOG2-1:0] pre;
    logic                tick;
    logic                cur;
    logic                fall;
    logic                rise;
    logic                timeout;
    logic [CNT_W-1:0]    len;

    assign tick = &pre;
    // cur holds the previous tick's sample; the incoming sample is sync2, so
    // edges are recognised (and acted on) in the very tick that captures them.
    assign fall    = tick &  cur & ~sync2;
    assign rise    = tick & ~cur &  sync2;
    assign timeout = tick & ~(fall | rise) & (len >= TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            pre   <= '0;
            cur   <= 1'b1;
            len   <= '0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            pre   <= pre + 1'b1;
            if (tick) begin
                cur <= sync2;
                if (fall || rise) begin
                    len <= LEN_ONE;
                end else if (len != LEN_SAT) begin
                    len <= len + 1'b1;
                end
            end
        end
    end

    // Decoder FSM
    state_t      state;
    state_t      state_n;
    logic [4:0]  idx;
    logic [4:0]  idx_n;
    logic [31:0] sr;
    logic [31:0] sr_n;
    logic [31:0] sr_shift;
    logic        have_last;
    logic        have_last_n;
    logic        valid_n;
    logic        rep_n;
    logic        err_n;
    logic [15:0] addr_n;
    logic [15:0] frame_addr;
    logic [7:0]  code_n;
    logic        ok_addr;
    logic        ok_cmd;

    always_comb begin
        // Bit value is taken from the space length measured at the closing fall.
        sr_shift = {(len >= BIT1_C), sr[31:1]};
        ok_cmd   = (sr_shift[31:24] == ~sr_shift[23:16]);
`ifdef IR_EXT_ADDR_EN
        ok_addr    = 1'b1;
        frame_addr = sr_shift[15:0];
`else
        ok_addr    = (sr_shift[15:8] == ~sr_shift[7:0]);
        frame_addr = {8'h00, sr_shift[7:0]};
`endif
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        sr_n        = sr;
        have_last_n = have_last;
        addr_n      = cmd_addr;
        code_n      = cmd_code;
        valid_n     = 1'b0;
        rep_n       = 1'b0;
        err_n       = 1'b0;

        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK: begin
                // A short mark is treated as noise and dropped without an error.
                if (rise) begin
                    state_n = (len >= LEAD_MARK_C) ? S_LEAD_SPACE : S_IDLE;
                end
            end
            S_LEAD_SPACE: begin
                if (fall) begin
                    if (len >= LEAD_SPACE_C) begin
                        state_n = S_BIT_MARK;
                        idx_n   = 5'd0;
                    end else if (len >= REP_SPACE_C) begin
                        state_n = S_REP_STOP;
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end
                end
            end
            S_BIT_MARK: begin
                if (rise) begin
                    if (len <= BIT_MARK_C) begin
                        state_n = S_BIT_SPACE;
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end
                end
            end
            S_BIT_SPACE: begin
                if (fall) begin
                    sr_n = sr_shift;
                    if (idx != 5'd31) begin
                        state_n = S_BIT_MARK;
                        idx_n   = idx + 5'd1;
                    end else begin
                        // The fall that closes bit 31 is the start of the stop
                        // mark; its rise arrives in IDLE and is ignored there.
                        state_n = S_IDLE;
                        if (ok_cmd && ok_addr) begin
                            valid_n     = 1'b1;
                            addr_n      = frame_addr;
                            code_n      = sr_shift[23:16];
                            have_last_n = 1'b1;
                        end else begin
                            err_n       = 1'b1;
                            have_last_n = 1'b0;
                        end
                    end
                end
            end
            S_REP_STOP: begin
                if (rise) begin
                    state_n = S_IDLE;
                    if (len <= BIT_MARK_C && have_last) begin
                        rep_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // The timeout only fires on ticks without an edge, so it never
        // competes with a decision taken above.
        if (state != S_IDLE && timeout) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= 5'd0;
            sr           <= 32'h0;
            have_last    <= 1'b0;
            cmd_valid    <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_err    <= 1'b0;
            cmd_addr     <= 16'h0000;
            cmd_code     <= 8'h00;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            sr           <= sr_n;
            have_last    <= have_last_n;
            cmd_valid    <= valid_n;
            repeat_pulse <= rep_n;
            frame_err    <= err_n;
            cmd_addr     <= addr_n;
            cmd_code     <= code_n;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb/tb_ir_nec_rx.sv - directed self-checking bench for ir_nec_rx

module tb_ir_nec_rx;

    logic        clk;
    logic        rst_n;
    logic        ir_in;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_code;
    logic        repeat_pulse;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Strobe monitor
    int          n_valid = 0;
    int          n_rep   = 0;
    int          n_err   = 0;
    int          n_overlap = 0;
    int          n_wide  = 0;
    logic        last_v  = 1'b0;
    logic        last_r  = 1'b0;
    logic        last_e  = 1'b0;
    logic [15:0] cap_addr = 16'h0;
    logic [7:0]  cap_code = 8'h0;

    // tick = clk/2 keeps whole frames short while thresholds stay nominal
    ir_nec_rx #(.DIV_LOG2(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_in        (ir_in),
        .cmd_valid    (cmd_valid),
        .cmd_addr     (cmd_addr),
        .cmd_code     (cmd_code),
        .repeat_pulse (repeat_pulse),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            cap_addr = cmd_addr;
            cap_code = cmd_code;
        end
        if (repeat_pulse) n_rep++;
        if (frame_err) n_err++;
        if ((int'(cmd_valid) + int'(repeat_pulse) + int'(frame_err)) > 1) n_overlap++;
        if ((cmd_valid && last_v) || (repeat_pulse && last_r) || (frame_err && last_e)) n_wide++;
        last_v = cmd_valid;
        last_r = repeat_pulse;
        last_e = frame_err;
    end

    // Timing in ticks (25.6 us nominal): 9 ms=352, 4.5 ms=176, 2.25 ms=88,
    // 562 us=22, 1687 us=66.
    task automatic hold(input logic lvl, input int ticks);
        ir_in = lvl;
        repeat (2 * ticks) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        hold(1'b0, 352);
        hold(1'b1, 176);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 22);
            hold(1'b1, w[i] ? 66 : 22);
        end
        if (nbits == 32) begin
            hold(1'b0, 22);
            hold(1'b1, 60);
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, 352);
        hold(1'b1, 88);
        hold(1'b0, 22);
        hold(1'b1, 60);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || repeat_pulse !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: got v=%b r=%b e=%b expected 0 0 0", cmd_valid, repeat_pulse, frame_err);
        end
        checks++;
        if (cmd_addr !== 16'h0000 || cmd_code !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got addr=%h code=%h expected 0000 00", cmd_addr, cmd_code);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_repeat_without_frame();
        int e0 = n_err;
        int r0 = n_rep;
        send_repeat();
        checks++;
        if (n_err - e0 !== 1) begin
            failures++;
            $display("FAIL rep_no_last_err: got %0d expected 1", n_err - e0);
        end
        checks++;
        if (n_rep - r0 !== 0) begin
            failures++;
            $display("FAIL rep_no_last_rep: got %0d expected 0", n_rep - r0);
        end
    endtask

    task automatic test_valid_frame();
        int v0 = n_valid;
        int e0 = n_err;
        send_word(32'h609FFF00, 32);
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL frame_valid_count: got %0d expected 1", n_valid - v0);
        end
        checks++;
        if (n_err - e0 !== 0) begin
            failures++;
            $display("FAIL frame_err_count: got %0d expected 0", n_err - e0);
        end
        checks++;
        if (cap_addr !== 16'h0000 || cap_code !== 8'h9F) begin
            failures++;
            $display("FAIL frame_data_at_strobe: got addr=%h code=%h expected 0000 9f", cap_addr, cap_code);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_repeat();
        int r0 = n_rep;
        int e0 = n_err;
        int v0 = n_valid;
        send_repeat();
        checks++;
        if (n_rep - r0 !== 1) begin
            failures++;
            $display("FAIL repeat_count: got %0d expected 1", n_rep - r0);
        end
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL repeat_other: got err=%0d valid=%0d expected 0 0", n_err - e0, n_valid - v0);
        end
        checks++;
        if (cmd_addr !== 16'h0000 || cmd_code !== 8'h9F) begin
            failures++;
            $display("FAIL repeat_hold: got addr=%h code=%h expected 0000 9f", cmd_addr, cmd_code);
        end
    endtask

    task automatic test_bad_inverse();
        int e0 = n_err;
        int v0 = n_valid;
        int r0 = n_rep;
        send_word(32'h619FFF00, 32);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL bad_inv: got err=%0d valid=%0d expected 1 0", n_err - e0, n_valid - v0);
        end
        checks++;
        if (cmd_addr !== 16'h0000 || cmd_code !== 8'h9F) begin
            failures++;
            $display("FAIL bad_inv_hold: got addr=%h code=%h expected 0000 9f", cmd_addr, cmd_code);
        end
        // last frame was rejected, so a repeat is now an error
        send_repeat();
        checks++;
        if (n_rep - r0 !== 0 || n_err - e0 !== 2) begin
            failures++;
            $display("FAIL bad_inv_repeat: got rep=%0d err=%0d expected 0 2", n_rep - r0, n_err - e0);
        end
    endtask

    task automatic test_glitch();
        int e0 = n_err;
        int v0 = n_valid;
        int r0 = n_rep;
        hold(1'b0, 40);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_mid: got %b expected 1", busy);
        end
        hold(1'b0, 38);
        hold(1'b1, 30);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_after: got %b expected 0", busy);
        end
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0 || n_rep - r0 !== 0) begin
            failures++;
            $display("FAIL glitch_strobes: got e=%0d v=%0d r=%0d expected 0 0 0", n_err - e0, n_valid - v0, n_rep - r0);
        end
    endtask

    task automatic test_timeout();
        int e0 = n_err;
        hold(1'b0, 390);
        checks++;
        if (n_err - e0 !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got err=%0d busy=%b expected 0 1", n_err - e0, busy);
        end
        hold(1'b0, 79);
        checks++;
        if (n_err - e0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: got err=%0d busy=%b expected 1 0", n_err - e0, busy);
        end
        hold(1'b1, 60);
        checks++;
        if (n_err - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_release: got err=%0d expected 1", n_err - e0);
        end
    endtask

    task automatic test_ext_addr();
        int e0 = n_err;
        int v0 = n_valid;
        send_word(32'hA9563412, 32);
`ifdef IR_EXT_ADDR_EN
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            failures++;
            $display("FAIL ext_counts: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
        end
        checks++;
        if (cmd_addr !== 16'h3412 || cmd_code !== 8'h56) begin
            failures++;
            $display("FAIL ext_data: got addr=%h code=%h expected 3412 56", cmd_addr, cmd_code);
        end
`else
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
            failures++;
            $display("FAIL std_addr_inv: got valid=%0d err=%0d expected 0 1", n_valid - v0, n_err - e0);
        end
        checks++;
        if (cmd_addr !== 16'h0000 || cmd_code !== 8'h9F) begin
            failures++;
            $display("FAIL std_addr_hold: got addr=%h code=%h expected 0000 9f", cmd_addr, cmd_code);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        int v0;
        int r0;
        send_word(32'hC33CA55A, 15);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        e0 = n_err;
        v0 = n_valid;
        r0 = n_rep;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (cmd_addr !== 16'h0000 || cmd_code !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs: got addr=%h code=%h busy=%b expected 0000 00 0", cmd_addr, cmd_code, busy);
        end
        rst_n = 1'b1;
        hold(1'b1, 40);
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0 || n_rep - r0 !== 0) begin
            failures++;
            $display("FAIL midrst_strobes: got e=%0d v=%0d r=%0d expected 0 0 0", n_err - e0, n_valid - v0, n_rep - r0);
        end
        send_word(32'hC33CA55A, 32);
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            failures++;
            $display("FAIL midrst_next_counts: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
        end
        checks++;
        if (cmd_addr !== 16'h005A || cmd_code !== 8'h3C) begin
            failures++;
            $display("FAIL midrst_next_data: got addr=%h code=%h expected 005a 3c", cmd_addr, cmd_code);
        end
    endtask

    task automatic test_strobe_shape();
        checks++;
        if (n_overlap !== 0) begin
            failures++;
            $display("FAIL strobe_exclusive: got %0d overlaps expected 0", n_overlap);
        end
        checks++;
        if (n_wide !== 0) begin
            failures++;
            $display("FAIL strobe_width: got %0d wide strobes expected 0", n_wide);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ir_in = 1'b1;
        test_reset();
        test_repeat_without_frame();
        test_valid_frame();
        test_repeat();
        test_bad_inverse();
        test_glitch();
        test_timeout();
        test_ext_addr();
        test_reset_mid_frame();
        test_strobe_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx.md
# ir_nec_rx

Parametrised NEC infrared frame receiver for the IR-controlled bot. It decodes the raw, active-low demodulated output of the IR receiver module into validated address/command pairs and repeat events. Leader detection, inverse-byte checking, repeat codes and timeouts are all handled. It sits between the IR pin and the motor-command logic, which consumes `cmd_valid`/`repeat_pulse` strobes.

## Interface
- `DIV_LOG2`, 11: tick prescaler; tick = `clk`/2^DIV_LOG2 (80 MHz → 39.06 kHz, 25.6 µs).
- `CNT_W`, 10: width of the pulse-length counter; saturates at 2^CNT_W−1.
- `LEAD_MARK_MIN`, 300: minimum leader mark, in ticks.
- `LEAD_SPACE_MIN`, 140: leader space ≥ this means data frame.
- `REP_SPACE_MIN`, 70: leader space in [REP_SPACE_MIN, LEAD_SPACE_MIN) means repeat.
- `BIT_MARK_MAX`, 40: maximum bit/stop mark, in ticks.
- `BIT1_MIN`, 44: bit space ≥ this decodes as 1, otherwise 0.
- `MAX_PULSE`, 400: any mark or space reaching this length aborts the frame.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ir_in` in 1: raw IR receiver output, asynchronous; idle high, mark = low.
- `cmd_valid` out 1: one-`clk` pulse when a valid frame completes.
- `cmd_addr` out 16: last valid address.
- `cmd_code` out 8: last valid command.
- `repeat_pulse` out 1: one-`clk` pulse on a valid repeat code.
- `frame_err` out 1: one-`clk` pulse on a malformed or aborted frame.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- `ir_in` passes through a 2-FF synchroniser on `clk`. A free-running DIV_LOG2-bit prescaler generates `tick`. The synced level is resampled on `tick` into `cur`/`prev`. Fall = prev 1, cur 0. Rise = prev 0, cur 1.
- Pulse counter `len`, updated on tick:
  - reloads to 1 on any edge;
  - otherwise increments, saturating.
  - The measured length at an edge is `len` before the reload.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_STOP.
- IDLE: fall → LEAD_MARK.
- LEAD_MARK, on rise:
  - len ≥ LEAD_MARK_MIN → LEAD_SPACE;
  - shorter → IDLE silently (noise, no `frame_err`).
- LEAD_SPACE, on fall:
  - len ≥ LEAD_SPACE_MIN → BIT_MARK, bit index 0;
  - len ≥ REP_SPACE_MIN → REP_STOP;
  - shorter → `frame_err`, IDLE.
- BIT_MARK, on rise: len ≤ BIT_MARK_MAX → BIT_SPACE; otherwise `frame_err`, IDLE.
- BIT_SPACE, on fall:
  - shift bit (len ≥ BIT1_MIN) into a 32-bit shift register, LSB first (byte0 = addr, byte1 = ~addr, byte2 = cmd, byte3 = ~cmd);
  - if index < 31 → BIT_MARK, index+1;
  - after bit 31 → validate → IDLE.
- Validation passes when byte3 == ~byte2 and (default build) byte1 == ~byte0.
  - Pass: `cmd_addr` = {8'h00, byte0}, `cmd_code` = byte2, `cmd_valid` pulses, `have_last` set.
  - Fail: `frame_err`, `have_last` cleared, outputs hold.
- REP_STOP, on rise with len ≤ BIT_MARK_MAX:
  - `repeat_pulse` if `have_last`, else `frame_err`;
  - → IDLE.
- Timeout: in any state but IDLE, `len` reaching MAX_PULSE before the expected edge → `frame_err`, IDLE. The trailing stop mark of a data frame is ignored: the decoder is in IDLE by then, and its rise is not a fall.
- A fall while in IDLE with the line already low cannot happen; a new frame starts only from a fall.

## Timing
- Reset values: all outputs 0, `cmd_addr`/`cmd_code` 0, FSM IDLE, `have_last` 0, prescaler/`len`/shift register 0, synchroniser and `cur`/`prev` 1 (idle line).
- Edge-to-decision latency: 2 `clk` (sync) + up to 2^DIV_LOG2 `clk` (tick alignment) + 1 `clk`.
- Strobes are registered and asserted in the `clk` cycle after the deciding tick. `cmd_addr`/`cmd_code` change in the same cycle `cmd_valid` is high.
- `cmd_valid`, `repeat_pulse` and `frame_err` are mutually exclusive and never longer than 1 `clk`.
- `rst_n` low mid-frame aborts immediately with no strobe. Decoding resumes at the next fall after release.

## Configuration
- `IR_EXT_ADDR_EN` defined (extended NEC):
  - the address inverse check is skipped;
  - `cmd_addr` = {byte1, byte0};
  - the command inverse check is still enforced.
- Not defined: standard NEC. Both inverse checks are enforced and `cmd_addr[15:8]` stays 0.

## Test plan
- Standard frame addr 8'h00, cmd 8'h9F (bytes 00 FF 9F 60), nominal NEC timing → one `cmd_valid`, `cmd_addr` = 16'h0000, `cmd_code` = 8'h9F, no `frame_err`.
- The same frame followed by a repeat code (9 ms mark, 2.25 ms space, 562 µs mark) → `repeat_pulse` once, outputs unchanged. A repeat sent right after reset → `frame_err`, no `repeat_pulse`.
- Frame with byte3 = 8'h61 → `frame_err`, `cmd_valid` never high, previous outputs held.
- 2 ms low glitch → no strobe, `busy` returns low. Line held low for 12 ms → `frame_err` at MAX_PULSE.
- Bytes 12 34 56 A9 → default build: `frame_err`; `IR_EXT_ADDR_EN` build: `cmd_addr` = 16'h3412, `cmd_code` = 8'h56.
- `rst_n` asserted at bit 15 of a frame → no strobe, all outputs 0. A complete valid frame after release decodes correctly.
